imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pkg.sv | 15 +
 rtl/imm_skid_buf.sv | 88 ++++++++
 rtl/imm_gen_pipe.sv | 86 ++++++++
 tb/tb_imm_gen_pipe.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Shared encodings for the immediate generator: extension modes and skid-buffer occupancy states.
package imm_gen_pkg;

    localparam logic [1:0] IMM_SEXT = 2'd0;
    localparam logic [1:0] REL_ZEXT = 2'd1;
    localparam logic [1:0] REL_SEXT = 2'd2;
    localparam logic [1:0] PC_REL   = 2'd3;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/imm_skid_buf.sv
// Two-entry skid buffer; one-cycle latency, head register drives the output directly.
// Backpressure: in_ready is registered and drops only when both entries are occupied; flush empties it.
module imm_skid_buf
    import imm_gen_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    buf_state_e   state;
    buf_state_e   state_nxt;
    logic [W-1:0] head;
    logic [W-1:0] skid;
    logic         rdy;
    logic         push;
    logic         pop;

    assign push      = in_valid & rdy & ~flush;
    assign pop       = (state != BUF_EMPTY) & out_ready;
    assign in_ready  = rdy;
    assign out_valid = (state != BUF_EMPTY);
    assign out_data  = head;

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = BUF_EMPTY;
        end else begin
            case (state)
                BUF_EMPTY: if (push) state_nxt = BUF_ONE;
                BUF_ONE: begin
                    if (push && !pop)
                        state_nxt = BUF_FULL;
                    else if (!push && pop)
                        state_nxt = BUF_EMPTY;
                end
                BUF_FULL:  if (pop) state_nxt = BUF_ONE;
                default:   state_nxt = BUF_EMPTY;
            endcase
        end
    end

    // in_ready is a pure register: it looks ahead at the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= BUF_EMPTY;
            rdy   <= 1'b1;
        end else begin
            state <= state_nxt;
            rdy   <= (state_nxt != BUF_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head <= '0;
            skid <= '0;
        end else if (!flush) begin
            case (state)
                BUF_EMPTY: begin
                    if (push)
                        head <= in_data;
                end
                BUF_ONE: begin
                    if (push && pop)
                        head <= in_data;
                    else if (push)
                        skid <= in_data;
                end
                BUF_FULL: begin
                    if (pop)
                        head <= skid;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate/relative-address extender with a 2-entry output skid buffer; 1-cycle latency, valid/ready both sides.
// IMM_GEN_PCREL_EN compiles in the mode-3 PC-relative adder; without it mode 3 returns the zero-extended field and flags out_err.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMM_W  = 3,
    parameter int REL_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_mode,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [REL_W-1:0]  in_rel,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] rel_zext;
    logic [DATA_W-1:0] rel_sext;
    logic [DATA_W-1:0] ext_data;
    logic              ext_err;
    logic [DATA_W:0]   buf_in;
    logic [DATA_W:0]   buf_out;

    assign imm_sext = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
    assign rel_zext = {{(DATA_W-REL_W){1'b0}}, in_rel};
    assign rel_sext = {{(DATA_W-REL_W){in_rel[REL_W-1]}}, in_rel};

`ifdef IMM_GEN_PCREL_EN
    logic [DATA_W-1:0] pc_rel;

    // Carry out is dropped so the target wraps around the address space.
    assign pc_rel = in_pc + rel_sext;
`else
    logic pc_unused;

    assign pc_unused = ^in_pc;
`endif

    always_comb begin
        ext_data = rel_zext;
        ext_err  = 1'b0;
        case (in_mode)
            IMM_SEXT: ext_data = imm_sext;
            REL_ZEXT: ext_data = rel_zext;
            REL_SEXT: ext_data = rel_sext;
            PC_REL: begin
`ifdef IMM_GEN_PCREL_EN
                ext_data = pc_rel;
`else
                ext_data = rel_zext;
                ext_err  = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    // Error bit travels with its own result through the buffer.
    assign buf_in   = {ext_err, ext_data};
    assign out_err  = buf_out[DATA_W];
    assign out_data = buf_out[DATA_W-1:0];

    imm_skid_buf #(
        .W (DATA_W + 1)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (buf_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (buf_out)
    );

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: directed cases plus randomized traffic against a queue-based reference model.
module tb_imm_gen_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_mode;
    logic [2:0] in_imm;
    logic [5:0] in_rel;
    logic [7:0] in_pc;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_err;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [8:0] q[$];

    imm_gen_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_imm    (in_imm),
        .in_rel    (in_rel),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: signed values as plain integers, result taken modulo 256.
    function automatic logic [8:0] ref_ext(input logic [1:0] m, input logic [2:0] imm,
                                           input logic [5:0] rel, input logic [7:0] pc);
        int   is;
        int   rs;
        int   r;
        logic e;
        is = imm[2] ? int'(imm) - 8 : int'(imm);
        rs = rel[5] ? int'(rel) - 64 : int'(rel);
        e  = 1'b0;
        case (m)
            2'd0:    r = is;
            2'd1:    r = int'(rel);
            2'd2:    r = rs;
            default: begin
`ifdef IMM_GEN_PCREL_EN
                r = int'(pc) + rs;
`else
                r = int'(rel);
                e = 1'b1;
`endif
            end
        endcase
        return {e, 8'(r)};
    endfunction

    task automatic step(input logic v, input logic [1:0] m, input logic [2:0] imm,
                        input logic [5:0] rel, input logic [7:0] pc,
                        input logic ordy, input logic fl);
        logic       pop;
        logic       acc;
        logic [8:0] r;
        in_valid  = v;
        in_mode   = m;
        in_imm    = imm;
        in_rel    = rel;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        pop = (q.size() > 0) && ordy;
        acc = v && (q.size() < 2);
        r   = ref_ext(m, imm, rel, pc);
        @(posedge clk);
        #1;
        if (!rst_n || fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(r);
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 2'd0, 3'd0, 6'd0, 8'd0, ordy, 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(1'b1, 2'd0, 3'd5, 6'd0, 8'd0, 1'b0, 1'b0);
        step(1'b1, 2'd1, 3'd0, 6'd9, 8'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got=%h want=00", out_data); end
        n_cmp++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err got=%b want=0", out_err); end
    endtask

    task automatic test_modes;
        logic [1:0] tm [6];
        logic [2:0] ti [6];
        logic [5:0] tr [6];
        logic [7:0] tp [6];
        logic [7:0] te [6];
        logic       tq [6];
        tm = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd3, 2'd0};
        ti = '{3'b101, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3};
        tr = '{6'd0, 6'b100000, 6'b100000, 6'h15, 6'h3F, 6'd0};
        tp = '{8'h00, 8'h00, 8'h00, 8'hF0, 8'hF0, 8'h00};
`ifdef IMM_GEN_PCREL_EN
        te = '{8'hFD, 8'hE0, 8'h20, 8'h05, 8'hEF, 8'h03};
        tq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
        te = '{8'hFD, 8'hE0, 8'h20, 8'h15, 8'h3F, 8'h03};
        tq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
`endif
        for (int i = 0; i < 6; i++) begin
            step(1'b1, tm[i], ti[i], tr[i], tp[i], 1'b1, 1'b0);
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mode_valid[%0d] got=%b want=1", i, out_valid); end
            n_cmp++; if (out_data !== te[i]) begin n_fail++; $display("FAIL mode_data[%0d] got=%h want=%h", i, out_data, te[i]); end
            n_cmp++; if (out_err !== tq[i]) begin n_fail++; $display("FAIL mode_err[%0d] got=%b want=%b", i, out_err, tq[i]); end
        end
        idle(1'b1);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mode_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_backpressure;
        step(1'b1, 2'd1, 3'd0, 6'd1, 8'd0, 1'b0, 1'b0);
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_one got=%b want=1", in_ready); end
        step(1'b1, 2'd1, 3'd0, 6'd2, 8'd0, 1'b0, 1'b0);
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full got=%b want=0", in_ready); end
        step(1'b1, 2'd1, 3'd0, 6'd3, 8'd0, 1'b0, 1'b0);
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_third got=%b want=0", in_ready); end
        n_cmp++; if (out_data !== 8'h01) begin n_fail++; $display("FAIL bp_hold got=%h want=01", out_data); end
        idle(1'b1);
        n_cmp++; if (out_data !== 8'h02 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_second got=%h/%b want=02/1", out_data, out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop got=%b want=1", in_ready); end
        idle(1'b1);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_third_dropped got=%b want=0", out_valid); end
    endtask

    task automatic test_flush;
        step(1'b1, 2'd1, 3'd0, 6'h11, 8'd0, 1'b0, 1'b0);
        step(1'b1, 2'd1, 3'd0, 6'h12, 8'd0, 1'b0, 1'b0);
        step(1'b1, 2'd1, 3'd0, 6'h13, 8'd0, 1'b1, 1'b1);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b want=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got=%b want=1", in_ready); end
        idle(1'b1);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_lost got=%b want=0", out_valid); end
    endtask

    task automatic test_reset_mid;
        step(1'b1, 2'd2, 3'd0, 6'h2A, 8'd0, 1'b0, 1'b0);
        step(1'b1, 2'd2, 3'd0, 6'h2B, 8'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        step(1'b1, 2'd2, 3'd0, 6'h2C, 8'd0, 1'b1, 1'b0);
        rst_n = 1'b1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_state got=%b/%b want=0/1", out_valid, in_ready); end
        idle(1'b1);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_residue got=%b want=0", out_valid); end
    endtask

    task automatic test_random;
        logic       v;
        logic [1:0] m;
        logic [2:0] imm;
        logic [5:0] rel;
        logic [7:0] pc;
        logic       ordy;
        logic       fl;
        for (int i = 0; i < 800; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            m    = 2'($urandom_range(0, 3));
            imm  = 3'($urandom);
            rel  = 6'($urandom);
            pc   = 8'($urandom);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 19) == 0);
            rst_n = ($urandom_range(0, 79) != 0);
            step(v, m, imm, rel, pc, ordy, fl);
            rst_n = 1'b1;
            n_cmp++; if (out_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid[%0d] got=%b want=%b", i, out_valid, q.size() > 0); end
            n_cmp++; if (in_ready !== (q.size() < 2)) begin n_fail++; $display("FAIL rnd_ready[%0d] got=%b want=%b", i, in_ready, q.size() < 2); end
            if (q.size() > 0) begin
                n_cmp++; if ({out_err, out_data} !== q[0]) begin n_fail++; $display("FAIL rnd_data[%0d] got=%h want=%h", i, {out_err, out_data}, q[0]); end
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 2'd0;
        in_imm    = 3'd0;
        in_rel    = 6'd0;
        in_pc     = 8'd0;
        flush     = 1'b0;
        out_ready = 1'b0;
        test_reset;
        test_modes;
        test_backpressure;
        test_flush;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
